// File: rtl/lcd_num_formatter.sv
// Formats a 16-bit unsigned value into 5 ASCII digits (double-dabble) and
// pushes them to the 16x2 LCD Avalon slave once the slave reports idle.
module lcd_num_formatter #(
    parameter int POLL_HOLDOFF = 256,
    parameter int POLL_TIMEOUT = 65535,
    parameter int LCD_IDLE_ST  = 5
) (
    input  logic        csi_CLK,
    input  logic        csi_RST_N,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [7:0]  in_row,
    input  logic [7:0]  in_pos,
    input  logic        in_blank,
    output logic        avm_chipselect,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int HW = $clog2(POLL_HOLDOFF + 1);
    localparam int TW = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_FORMAT,
        S_POLL_RD,
        S_POLL_WAIT,
        S_WR_CHAR,
        S_WR_CMD,
        S_HOLDOFF
    } state_t;

    state_t          state, state_nxt;
    logic [15:0]     value_sh;
    logic [19:0]     bcd, bcd_adj;
    logic [3:0]      iter;
    logic [7:0]      row_q;
    logic [3:0]      pos_q;
    logic            blank_q;
    logic [7:0]      chars [0:4];
    logic [7:0]      chars_fmt [0:4];
    logic [2:0]      idx;
    logic [TW-1:0]   poll_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            done_nxt, err_nxt;
    logic            timeout_hit;
    logic            lead;
    logic [3:0]      nib;

    // Upper address/data bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{in_pos[7:4], avm_readdata[31:6]};

    assign timeout_hit = (poll_cnt == TW'(POLL_TIMEOUT - 1));

    always_comb begin
        bcd_adj = bcd;
        nib     = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            nib = bcd[4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Blanking stops at the first non-zero digit; digit 4 is always numeric.
    always_comb begin
        lead = blank_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (lead && (bcd[4*(4-i) +: 4] == 4'd0) && (i < 4)) begin
                chars_fmt[i] = 8'h20;
            end else begin
                chars_fmt[i] = 8'h30 + {4'h0, bcd[4*(4-i) +: 4]};
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge csi_CLK or negedge csi_RST_N) begin
        if (!csi_RST_N) begin
            state <= S_IDLE;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            error <= err_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        avm_chipselect = 1'b0;
        avm_read       = 1'b0;
        avm_write      = 1'b0;
        avm_address    = '0;
        avm_writedata  = '0;
        case (state)
            S_IDLE: begin
                if (in_valid) state_nxt = S_CONVERT;
            end
            S_CONVERT: begin
                if (iter == 4'd15) state_nxt = S_FORMAT;
            end
            S_FORMAT: state_nxt = S_POLL_RD;
            S_POLL_RD: begin
                avm_chipselect = 1'b1;
                avm_read       = 1'b1;
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                if (avm_readdata[5:0] == 6'(LCD_IDLE_ST)) begin
                    state_nxt = S_WR_CHAR;
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = S_POLL_RD;
                end
            end
            S_WR_CHAR: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_address    = {2'b00, idx} + 5'd1;
                avm_writedata  = {24'h0, chars[idx]};
                if (idx == 3'd4) state_nxt = S_WR_CMD;
            end
            S_WR_CMD: begin
                avm_chipselect = 1'b1;
                avm_write      = 1'b1;
                avm_writedata  = {4'h0, pos_q, 8'd5, row_q, 8'h33};
                state_nxt      = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (hold_cnt == HW'(POLL_HOLDOFF - 1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_CLK or negedge csi_RST_N) begin
        if (!csi_RST_N) begin
            value_sh <= '0;
            bcd      <= '0;
            iter     <= '0;
            row_q    <= '0;
            pos_q    <= '0;
            blank_q  <= 1'b0;
            idx      <= '0;
            poll_cnt <= '0;
            hold_cnt <= '0;
            for (int unsigned i = 0; i < 5; i++) chars[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        value_sh <= in_value;
                        bcd      <= '0;
                        iter     <= '0;
                        row_q    <= in_row;
                        pos_q    <= (in_pos[3:0] > 4'd11) ? 4'd11 : in_pos[3:0];
                        blank_q  <= in_blank;
                    end
                end
                S_CONVERT: begin
                    {bcd, value_sh} <= {bcd_adj[18:0], value_sh, 1'b0};
                    iter            <= iter + 4'd1;
                end
                S_FORMAT: begin
                    for (int unsigned i = 0; i < 5; i++) chars[i] <= chars_fmt[i];
                    idx      <= '0;
                    poll_cnt <= '0;
                end
                S_POLL_RD, S_POLL_WAIT: poll_cnt <= poll_cnt + TW'(1);
                S_WR_CHAR: idx <= idx + 3'd1;
                S_WR_CMD:  hold_cnt <= '0;
                S_HOLDOFF: hold_cnt <= hold_cnt + HW'(1);
                default: ;
            endcase
        end
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Scoreboard bench: expected bus writes are queued per request and a
// negedge monitor pops and compares them as the DUT issues writes.
module tb_lcd_num_formatter;

    localparam int HOLD = 40;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = '0;
    logic [7:0]  in_row = '0;
    logic [7:0]  in_pos = '0;
    logic        in_blank = 1'b0;
    logic        avm_chipselect;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        busy, done, error;

    lcd_num_formatter #(
        .POLL_HOLDOFF(HOLD),
        .POLL_TIMEOUT(TMO),
        .LCD_IDLE_ST(5)
    ) dut (
        .csi_CLK(clk),
        .csi_RST_N(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_value(in_value),
        .in_row(in_row),
        .in_pos(in_pos),
        .in_blank(in_blank),
        .avm_chipselect(avm_chipselect),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   cmd_cyc = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    int   rd_at_wr = -1;
    int   n_done = 0;
    int   n_err = 0;
    int   srv = 0;
    int   busy_polls = 0;
    logic [5:0] busy_val = 6'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave model: status is busy_val for the first busy_polls reads, then idle.
    always @(posedge clk) begin
        if (avm_read) begin
            avm_readdata <= {26'h2AAAAAA, (srv < busy_polls) ? busy_val : 6'd5};
            srv = srv + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (avm_chipselect || avm_read || avm_write)
                chk("strobe_rules", {30'd0, avm_read && avm_write,
                    avm_chipselect != (avm_read || avm_write)}, 32'd0);
            if (avm_read) rd_cnt++;
            if (avm_write) begin
                if (wr_cnt == 0) rd_at_wr = rd_cnt;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("wr_expected", 32'd0, 32'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", {27'd0, avm_address}, {27'd0, e.a});
                    chk("wr_data", avm_writedata, e.d);
                end
                if (avm_address == 5'd0) cmd_cyc = cyc;
            end
            if (done) begin
                n_done++;
                chk("done_latency", cyc - cmd_cyc, HOLD + 1);
            end
            if (error) n_err++;
        end
    end

    task automatic start_req(input logic [15:0] v, input logic [7:0] row, input logic [7:0] pos,
                             input logic blank, input int polls, input logic [5:0] bval);
        bit acc;
        rd_cnt = 0; wr_cnt = 0; rd_at_wr = -1; n_done = 0; n_err = 0;
        srv = 0; busy_polls = polls; busy_val = bval;
        @(negedge clk);
        in_value = v; in_row = row; in_pos = pos; in_blank = blank; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50; n++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_req(input logic [15:0] v, input logic [7:0] row, input logic [7:0] pos,
                           input logic blank, input int polls, input logic [5:0] bval,
                           input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input logic [7:0] c3, input logic [7:0] c4,
                           input logic [31:0] cmd, input bit exp_err);
        bit fin;
        if (!exp_err) begin
            exp_q.push_back(wr_t'{a: 5'd1, d: {24'h0, c0}});
            exp_q.push_back(wr_t'{a: 5'd2, d: {24'h0, c1}});
            exp_q.push_back(wr_t'{a: 5'd3, d: {24'h0, c2}});
            exp_q.push_back(wr_t'{a: 5'd4, d: {24'h0, c3}});
            exp_q.push_back(wr_t'{a: 5'd5, d: {24'h0, c4}});
            exp_q.push_back(wr_t'{a: 5'd0, d: cmd});
        end
        start_req(v, row, pos, blank, polls, bval);
        fin = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(posedge clk);
            if (n_done != 0 || n_err != 0) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk("completion_timeout", 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_count", n_done, exp_err ? 0 : 1);
        chk("error_count", n_err, exp_err ? 1 : 0);
        chk("write_count", wr_cnt, exp_err ? 0 : 6);
        chk("queue_empty", exp_q.size(), 0);
        if (!exp_err) begin
            chk("read_count", rd_cnt, polls + 1);
            chk("reads_before_write", rd_at_wr, polls + 1);
        end
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_outputs", {27'd0, busy, done, error, avm_read, avm_write}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, in_ready, busy}, 32'd2);

        run_req(16'd1234, 8'h00, 8'd0, 1'b1, 0, 6'd0,
                8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 32'h00050033, 1'b0);
        run_req(16'd65535, 8'h40, 8'd3, 1'b0, 0, 6'd0,
                8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 32'h03054033, 1'b0);
        run_req(16'd0, 8'h00, 8'd0, 1'b1, 0, 6'd0,
                8'h20, 8'h20, 8'h20, 8'h20, 8'h30, 32'h00050033, 1'b0);
        run_req(16'd0, 8'h00, 8'd0, 1'b0, 0, 6'd0,
                8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 32'h00050033, 1'b0);
        run_req(16'd907, 8'h40, 8'd14, 1'b1, 40, 6'd9,
                8'h20, 8'h20, 8'h39, 8'h30, 8'h37, 32'h0B054033, 1'b0);
        run_req(16'd10, 8'h00, 8'hF7, 1'b1, 0, 6'd0,
                8'h20, 8'h20, 8'h20, 8'h31, 8'h30, 32'h07050033, 1'b0);
        run_req(16'd55, 8'h00, 8'd0, 1'b1, 1000, 6'd12,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 1'b1);

        // Reset while the third character write is on the bus.
        exp_q.push_back(wr_t'{a: 5'd1, d: 32'h30});
        exp_q.push_back(wr_t'{a: 5'd2, d: 32'h34});
        start_req(16'd4321, 8'h00, 8'd0, 1'b0, 0, 6'd0);
        hit = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk);
            if (wr_cnt == 2) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) chk("mid_reset_reach", 32'd0, 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("mid_rst_strobes", {29'd0, avm_chipselect, avm_read, avm_write}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_writes", wr_cnt, 2);
        chk("mid_rst_queue", exp_q.size(), 0);
        chk("mid_rst_no_done", n_done, 0);
        exp_q.delete();

        run_req(16'd1234, 8'h00, 8'd0, 1'b1, 0, 6'd0,
                8'h20, 8'h31, 8'h32, 8'h33, 8'h34, 32'h00050033, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_num_formatter.md
Name: lcd_num_formatter

Overview:
Upstream feeder for the 16x2 character-LCD Avalon slave. It accepts a 16-bit unsigned result, such as a CNN class index or score, through a valid/ready handshake. It converts the value to 5 decimal ASCII characters using sequential double-dabble, with optional leading-zero blanking. As an Avalon-MM master it polls the LCD slave until idle, loads character registers 1..5, then issues a write-data command at register 0.

Parameters:
POLL_HOLDOFF, 256, clocks to wait after a command write before status polling resumes (covers the slave's 1 MHz FSM start-up)
POLL_TIMEOUT, 65535, max clocks spent polling for idle before aborting with error
LCD_IDLE_ST, 5, status value in readdata[5:0] meaning the LCD FSM is idle

Ports:
csi_CLK  in  1  system clock (100 MHz)
csi_RST_N  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_value  in  16  unsigned value to display
in_row  in  8  DDRAM row offset (8'h00 row 0, 8'h40 row 1)
in_pos  in  8  column of first character
in_blank  in  1  1 = leading zeros shown as space (8'h20)
avm_chipselect  out  1  master chipselect
avm_address  out  5  slave register index (word index, not byte)
avm_read  out  1  read strobe
avm_readdata  in  32  slave read data, valid the cycle after avm_read
avm_write  out  1  write strobe
avm_writedata  out  32  write data
busy  out  1  high from accept until return to IDLE
done  out  1  one-cycle pulse, display update issued
error  out  1  one-cycle pulse, poll timeout, nothing written

Behaviour:
- One clock (csi_CLK). Asynchronous active-low reset csi_RST_N.
- Reset values: all outputs 0, except in_ready = 1. FSM goes to IDLE and counters clear.
- Reset mid-operation aborts immediately. No further bus strobes are issued.
- Handshake: a request is accepted on the edge where in_valid && in_ready. All inputs are latched on that edge. in_ready = 1 only in IDLE.
- Latched in_pos[3:0] > 11 is clamped to 11, so 5 characters fit on a 16-column row. in_pos[7:4] is ignored.
- FSM states:
  - IDLE -> CONVERT on accept.
  - CONVERT: 16 iterations, one per clock. Each iteration adds 3 to any BCD nibble >= 5, then shifts left by one with the next value MSB. Result is a 20-bit BCD. -> FORMAT.
  - FORMAT (1 clk): char[i] = 8'h30 + digit[i]. Digit 0 is the most significant (ten-thousands). If blanking is on, leading zeros become 8'h20, but the least-significant digit is always numeric. -> POLL_RD.
  - POLL_RD (1 clk): chipselect = 1, read = 1, address = 0. -> POLL_WAIT.
  - POLL_WAIT (1 clk): sample readdata[5:0]. If it equals LCD_IDLE_ST -> WR_CHAR. Otherwise -> POLL_RD.
  - WR_CHAR: 5 consecutive cycles, each with chipselect = 1, write = 1. Address k = 1..5, writedata = {24'h0, char[k-1]}. -> WR_CMD.
  - WR_CMD (1 clk): address 0, writedata = {pos, 8'd5, row, 8'h33}. -> HOLDOFF.
  - HOLDOFF: wait POLL_HOLDOFF clocks, then pulse done -> IDLE.
- The slave has no waitrequest, so every strobe is exactly one cycle.
- Read and write are never asserted together. chipselect is asserted only with a strobe.
- Poll timeout counter:
  - Starts on entering POLL_RD the first time. Counts every clock in POLL_RD/POLL_WAIT.
  - Reaching POLL_TIMEOUT -> pulse error, go to IDLE, no writes issued.
- Back-to-back requests: a request presented during busy waits (in_ready = 0). Nothing is dropped or queued internally.
- in_valid deasserting before acceptance is legal. Nothing happens.

Test Plan:
1. Reset, then value 16'd1234, row 8'h00, pos 0, blank = 1, slave status 5 -> one read at addr 0, then writes addr1..5 = 20,31,32,33,34 (hex), addr0 = 32'h00050033. done pulses POLL_HOLDOFF+1 clocks after the command write.
2. Value 16'd65535, blank = 0, row 8'h40, pos 3 -> chars 36,35,35,33,35. Command 32'h03054033.
3. Value 0, blank = 1 -> chars 20,20,20,20,30. Value 0, blank = 0 -> 30,30,30,30,30.
4. Slave status 9 for 40 polls, then 5 -> exactly 41 reads, no write before the status-5 sample. pos 14 is clamped to 11 (command 32'h0B05xx33).
5. Status stuck at 12 with POLL_TIMEOUT = 100 -> error pulses once, zero writes, in_ready returns to 1.
6. Reset asserted during WR_CHAR after address 2 -> all strobes 0 immediately, in_ready = 1 after release. A new request then completes normally.
